// File: rtl/tick_rate_controller.sv
// Run/pause/step timebase: one divider drives a one-cycle tick and a toggling clk_out; four power-of-two rates.
// Tick lands term+1 cycles after RUNNING entry or one cycle after an accepted step; no backpressure, rate changes wait for a period boundary.
module tick_rate_controller #(
  parameter int unsigned BASE_DIV = 49_999_999,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       faster,
  input  logic       slower,
  output logic       tick,
  output logic       clk_out,
  output logic [1:0] level,
  output logic       running
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    STEP    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TERM0 = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'(((BASE_DIV + 1) >> 1) - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'(((BASE_DIV + 1) >> 2) - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'(((BASE_DIV + 1) >> 3) - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] term;
  logic [1:0]       pending;
  logic [1:0]       pending_nxt;
  logic             at_term;

  always_comb begin
    term = TERM0;
    case (level)
      2'd0:    term = TERM0;
      2'd1:    term = TERM1;
      2'd2:    term = TERM2;
      default: term = TERM3;
    endcase
  end

  // Simultaneous faster/slower cancel; both ends saturate.
  always_comb begin
    pending_nxt = pending;
    if (faster && !slower && pending != 2'd3)
      pending_nxt = pending + 2'd1;
    else if (slower && !faster && pending != 2'd0)
      pending_nxt = pending - 2'd1;
  end

  assign at_term = (counter == term);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= PAUSED;
      counter <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      level   <= 2'd0;
      pending <= 2'd0;
      running <= 1'b0;
    end else begin
      pending <= pending_nxt;
      tick    <= 1'b0;
      case (state)
        PAUSED: begin
          counter <= '0;
          level   <= pending;
          if (run) begin
            state   <= RUNNING;
            running <= 1'b1;
          end else if (step) begin
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            state   <= STEP;
          end
        end
        RUNNING: begin
          // Pause wins over a terminal count on the same edge.
          if (!run) begin
            state   <= PAUSED;
            running <= 1'b0;
            counter <= '0;
          end else if (at_term) begin
            counter <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            level   <= pending;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        STEP: begin
          // Lockout: one full period must elapse before the next step is honoured.
          if (at_term) begin
            counter <= '0;
            state   <= PAUSED;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          state   <= PAUSED;
          running <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller with BASE_DIV=15 (periods 16/8/4/2 cycles).
module tb_tick_rate_controller;

  logic       clk_in;
  logic       reset;
  logic       run;
  logic       step;
  logic       faster;
  logic       slower;
  logic       tick;
  logic       clk_out;
  logic [1:0] level;
  logic       running;

  int pass_cnt;
  int check_cnt;

  tick_rate_controller #(
    .BASE_DIV(15),
    .CNT_W   (5)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .run    (run),
    .step   (step),
    .faster (faster),
    .slower (slower),
    .tick   (tick),
    .clk_out(clk_out),
    .level  (level),
    .running(running)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one active edge, then settle 1 time unit past it.
  task automatic step_clk();
    @(posedge clk_in);
    #1;
  endtask

  // Edges until tick is seen (starting from the next edge); -1 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (tick !== 1'b1 && n < 100);
    if (tick !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; faster = 1'b0; slower = 1'b0;
    step_clk();
    step_clk();
    check_cnt++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else pass_cnt++;
    check_cnt++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out got %b want 0", clk_out); else pass_cnt++;
    check_cnt++; if (level !== 2'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else pass_cnt++;
    reset = 1'b0;
    step_clk();
    check_cnt++; if (tick !== 1'b0 || running !== 1'b0) $display("FAIL idle_paused tick=%b running=%b want 0/0", tick, running); else pass_cnt++;
  endtask

  task automatic test_free_run();
    int n;
    run = 1'b1;
    step_clk();
    check_cnt++; if (running !== 1'b1) $display("FAIL run_entry_running got %b want 1", running); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 16) $display("FAIL free_first_tick got %0d want 16", n); else pass_cnt++;
    check_cnt++; if (clk_out !== 1'b1) $display("FAIL free_clk_out1 got %b want 1", clk_out); else pass_cnt++;
    check_cnt++; if (level !== 2'd0) $display("FAIL free_level got %0d want 0", level); else pass_cnt++;
    step_clk();
    check_cnt++; if (tick !== 1'b0) $display("FAIL tick_one_cycle got %b want 0", tick); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 15) $display("FAIL free_second_tick got %0d want 15", n); else pass_cnt++;
    check_cnt++; if (clk_out !== 1'b0) $display("FAIL free_clk_out2 got %b want 0", clk_out); else pass_cnt++;
  endtask

  task automatic test_mid_faster();
    int n;
    for (int i = 0; i < 5; i++) step_clk();
    faster = 1'b1;
    step_clk();
    faster = 1'b0;
    check_cnt++; if (level !== 2'd0) $display("FAIL mid_level_held got %0d want 0", level); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 10) $display("FAIL mid_period_kept got %0d want 10", n); else pass_cnt++;
    check_cnt++; if (level !== 2'd1) $display("FAIL mid_level_at_tick got %0d want 1", level); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 8) $display("FAIL level1_period got %0d want 8", n); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 5; i++) begin
      faster = 1'b1;
      step_clk();
      faster = 1'b0;
      step_clk();
    end
    wait_tick(n);
    check_cnt++; if (level !== 2'd3) $display("FAIL sat_level_top got %0d want 3", level); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 2) $display("FAIL level3_period got %0d want 2", n); else pass_cnt++;
    faster = 1'b1; slower = 1'b1;
    step_clk();
    faster = 1'b0; slower = 1'b0;
    wait_tick(n);
    wait_tick(n);
    check_cnt++; if (level !== 2'd3) $display("FAIL conflict_level got %0d want 3", level); else pass_cnt++;
    check_cnt++; if (n !== 2) $display("FAIL conflict_period got %0d want 2", n); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      slower = 1'b1;
      step_clk();
      slower = 1'b0;
      step_clk();
    end
    wait_tick(n);
    check_cnt++; if (level !== 2'd0) $display("FAIL sat_level_bottom got %0d want 0", level); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 16) $display("FAIL level0_period got %0d want 16", n); else pass_cnt++;
  endtask

  task automatic test_pause();
    int   n;
    int   ticks;
    logic held;
    for (int i = 0; i < 10; i++) step_clk();
    held = clk_out;
    run = 1'b0;
    step_clk();
    check_cnt++; if (running !== 1'b0) $display("FAIL pause_running got %b want 0", running); else pass_cnt++;
    check_cnt++; if (tick !== 1'b0) $display("FAIL pause_tick got %b want 0", tick); else pass_cnt++;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      if (tick === 1'b1) ticks++;
    end
    check_cnt++; if (ticks !== 0) $display("FAIL pause_quiet got %0d ticks want 0", ticks); else pass_cnt++;
    check_cnt++; if (clk_out !== held) $display("FAIL pause_clk_out got %b want %b", clk_out, held); else pass_cnt++;
    run = 1'b1;
    step_clk();
    wait_tick(n);
    check_cnt++; if (n !== 16) $display("FAIL resume_first_tick got %0d want 16", n); else pass_cnt++;
    // Drop run exactly at the terminal count: pause must suppress the tick.
    for (int i = 0; i < 15; i++) step_clk();
    held = clk_out;
    run = 1'b0;
    step_clk();
    check_cnt++; if (tick !== 1'b0) $display("FAIL pause_at_term_tick got %b want 0", tick); else pass_cnt++;
    check_cnt++; if (clk_out !== held) $display("FAIL pause_at_term_clk got %b want %b", clk_out, held); else pass_cnt++;
    step_clk();
  endtask

  task automatic test_step();
    int   n;
    logic c0;
    logic exp_tick;
    c0 = clk_out;
    step = 1'b1;
    step_clk();
    step = 1'b0;
    check_cnt++; if (tick !== 1'b1) $display("FAIL step_tick got %b want 1", tick); else pass_cnt++;
    check_cnt++; if (clk_out !== ~c0) $display("FAIL step_clk_out got %b want %b", clk_out, ~c0); else pass_cnt++;
    for (int k = 1; k <= 17; k++) begin
      step = (k == 3 || k == 16 || k == 17);
      step_clk();
      step = 1'b0;
      exp_tick = (k == 17);
      check_cnt++; if (tick !== exp_tick) $display("FAIL step_lockout_k%0d got %b want %b", k, tick, exp_tick); else pass_cnt++;
    end
    check_cnt++; if (clk_out !== c0) $display("FAIL step_second_clk got %b want %b", clk_out, c0); else pass_cnt++;
    // run raised while in the lockout must wait for it to finish.
    for (int k = 1; k <= 17; k++) begin
      run = (k >= 2);
      step_clk();
      if (k == 16 || k == 17) begin
        check_cnt++;
        if (running !== (k == 17)) $display("FAIL step_run_k%0d got %b want %b", k, running, (k == 17));
        else pass_cnt++;
      end
    end
    wait_tick(n);
    check_cnt++; if (n !== 16) $display("FAIL step_then_run got %0d want 16", n); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    faster = 1'b1; step_clk(); faster = 1'b0; step_clk();
    faster = 1'b1; step_clk(); faster = 1'b0;
    wait_tick(n);
    check_cnt++; if (level !== 2'd2) $display("FAIL pre_reset_level got %0d want 2", level); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 4) $display("FAIL level2_period got %0d want 4", n); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    check_cnt++; if (tick !== 1'b0) $display("FAIL arst_tick got %b want 0", tick); else pass_cnt++;
    check_cnt++; if (clk_out !== 1'b0) $display("FAIL arst_clk_out got %b want 0", clk_out); else pass_cnt++;
    check_cnt++; if (level !== 2'd0) $display("FAIL arst_level got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (running !== 1'b0) $display("FAIL arst_running got %b want 0", running); else pass_cnt++;
    #2 reset = 1'b0;
    step_clk();
    check_cnt++; if (running !== 1'b1) $display("FAIL post_reset_running got %b want 1", running); else pass_cnt++;
    wait_tick(n);
    check_cnt++; if (n !== 16) $display("FAIL post_reset_tick got %0d want 16", n); else pass_cnt++;
    check_cnt++; if (clk_out !== 1'b1) $display("FAIL post_reset_clk got %b want 1", clk_out); else pass_cnt++;
    check_cnt++; if (level !== 2'd0) $display("FAIL post_reset_level got %0d want 0", level); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    test_reset();
    test_free_run();
    test_mid_faster();
    test_saturation();
    test_pause();
    test_step();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
